// File: rtl/lane_frame_composer.sv
// Purpose: composes the 8x8 red/green LED frame from note lanes, hit/miss flashes, score bar and win blink.
// Latency: 1 cycle; the frame registered at an edge reflects the inputs and state sampled at that edge.
// Backpressure: none; 'stop' freezes every state and output register until released.
module lane_frame_composer #(
  parameter int FLASH_CYCLES = 64,
  parameter int BLINK_CYCLES = 256,
  parameter int WIN_SCORE    = 10
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            stop,
  input  logic [4:0]      lane0,
  input  logic [4:0]      lane1,
  input  logic [4:0]      lane2,
  input  logic [4:0]      lane3,
  input  logic [1:0]      point0,
  input  logic [1:0]      point1,
  input  logic [1:0]      point2,
  input  logic [1:0]      point3,
  input  logic [4:0]      total,
  output logic [7:0][7:0] red_array,
  output logic [7:0][7:0] green_array
);

  localparam int FCW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [FCW-1:0] FLASH_LOAD = FCW'(FLASH_CYCLES - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_CYCLES - 1);
  localparam logic [4:0]     WIN_TH     = 5'(WIN_SCORE);

  localparam logic [1:0] FL_NONE = 2'b00;
  localparam logic [1:0] FL_HIT  = 2'b01;
  localparam logic [1:0] FL_MISS = 2'b10;

  typedef enum logic [1:0] {PLAY, WIN_ON, WIN_OFF} state_t;

  state_t               state, state_nxt;
  logic [BCW-1:0]       blink_cnt, blink_nxt;
  logic [3:0][FCW-1:0]  flash_cnt, flash_cnt_nxt;
  logic [3:0][1:0]      flash_type, flash_type_nxt;
  logic [7:0][7:0]      red_nxt, green_nxt;

  logic [3:0][4:0]      lanes;
  logic [3:0][1:0]      points;
  logic                 win_req;

  assign lanes   = {lane3, lane2, lane1, lane0};
  assign points  = {point3, point2, point1, point0};
  assign win_req = (total >= WIN_TH);

  // Game-state and blink sequencing: score exit takes priority over the blink toggle.
  always_comb begin
    state_nxt = state;
    blink_nxt = blink_cnt;
    case (state)
      PLAY: begin
        if (win_req) begin
          state_nxt = WIN_ON;
          blink_nxt = '0;
        end
      end
      WIN_ON, WIN_OFF: begin
        if (!win_req) begin
          state_nxt = PLAY;
          blink_nxt = '0;
        end else if (blink_cnt == BLINK_LAST) begin
          state_nxt = (state == WIN_ON) ? WIN_OFF : WIN_ON;
          blink_nxt = '0;
        end else begin
          blink_nxt = blink_cnt + BCW'(1);
        end
      end
      default: begin
        state_nxt = PLAY;
        blink_nxt = '0;
      end
    endcase
  end

  // Per-lane flash timers: events only count while staying in PLAY; any win entry/exit clears them.
  always_comb begin
    flash_cnt_nxt  = flash_cnt;
    flash_type_nxt = flash_type;
    for (int i = 0; i < 4; i++) begin
      if (state == PLAY && state_nxt == PLAY) begin
        if (points[i] == FL_HIT || points[i] == FL_MISS) begin
          flash_type_nxt[i] = points[i];
          flash_cnt_nxt[i]  = FLASH_LOAD;
        end else if (flash_cnt[i] != '0) begin
          flash_cnt_nxt[i]  = flash_cnt[i] - FCW'(1);
        end else begin
          flash_type_nxt[i] = FL_NONE;
        end
      end else begin
        flash_type_nxt[i] = FL_NONE;
        flash_cnt_nxt[i]  = '0;
      end
    end
  end

  // Frame assembly from the next state so the registered frame has one cycle of latency.
  always_comb begin
    red_nxt   = '0;
    green_nxt = '0;
    case (state_nxt)
      WIN_ON:  green_nxt = '1;
      WIN_OFF: green_nxt = '0;
      default: begin
        for (int i = 0; i < 4; i++) begin
          for (int r = 0; r < 5; r++) begin
            green_nxt[r][2*i] = lanes[i][r];
          end
          if (flash_type_nxt[i] == FL_HIT) begin
            green_nxt[5][2*i]   = 1'b1;
            green_nxt[5][2*i+1] = 1'b1;
            green_nxt[6][2*i]   = 1'b1;
            green_nxt[6][2*i+1] = 1'b1;
          end else if (flash_type_nxt[i] == FL_MISS) begin
            red_nxt[5][2*i]     = 1'b1;
            red_nxt[5][2*i+1]   = 1'b1;
            red_nxt[6][2*i]     = 1'b1;
            red_nxt[6][2*i+1]   = 1'b1;
          end
        end
        // Score bar: thermometer of total/4, green only.
        for (int c = 0; c < 8; c++) begin
          green_nxt[7][c] = (c < int'(total[4:2]));
        end
      end
    endcase
  end

  // State, timers and frame registers; reset wins over stop, stop freezes everything.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= PLAY;
      blink_cnt   <= '0;
      flash_cnt   <= '0;
      flash_type  <= '0;
      red_array   <= '0;
      green_array <= '0;
    end else if (!stop) begin
      state       <= state_nxt;
      blink_cnt   <= blink_nxt;
      flash_cnt   <= flash_cnt_nxt;
      flash_type  <= flash_type_nxt;
      red_array   <= red_nxt;
      green_array <= green_nxt;
    end
  end

endmodule

// File: tb/tb_lane_frame_composer.sv
// Purpose: directed self-checking bench for lane_frame_composer (flash timing, score bar, win blink, stop, reset).
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: n/a; 'stop' freeze is exercised directly.
module tb_lane_frame_composer;

  logic            Clock;
  logic            Reset;
  logic            stop;
  logic [4:0]      lane0, lane1, lane2, lane3;
  logic [1:0]      point0, point1, point2, point3;
  logic [4:0]      total;
  logic [7:0][7:0] red_a, green_a;
  logic [7:0][7:0] red_b, green_b;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] ALL_ON = 64'hFFFF_FFFF_FFFF_FFFF;

  // Main instance: short flash and blink, win at 10.
  lane_frame_composer #(.FLASH_CYCLES(4), .BLINK_CYCLES(3), .WIN_SCORE(10)) dut (
    .Clock(Clock), .Reset(Reset), .stop(stop),
    .lane0(lane0), .lane1(lane1), .lane2(lane2), .lane3(lane3),
    .point0(point0), .point1(point1), .point2(point2), .point3(point3),
    .total(total), .red_array(red_a), .green_array(green_a)
  );

  // Second instance with the highest win threshold so high scores still show the bar.
  lane_frame_composer #(.FLASH_CYCLES(4), .BLINK_CYCLES(3), .WIN_SCORE(31)) dut_bar (
    .Clock(Clock), .Reset(Reset), .stop(stop),
    .lane0(lane0), .lane1(lane1), .lane2(lane2), .lane3(lane3),
    .point0(point0), .point1(point1), .point2(point2), .point3(point3),
    .total(total), .red_array(red_b), .green_array(green_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Single pixel at [row][col] in the flattened frame.
  function automatic logic [63:0] px(input int r, input int c);
    logic [63:0] v;
    v = '0;
    v[r*8+c] = 1'b1;
    return v;
  endfunction

  // Flash zone of lane i: rows 5-6, columns 2i and 2i+1.
  function automatic logic [63:0] zone(input int i);
    return px(5, 2*i) | px(5, 2*i+1) | px(6, 2*i) | px(6, 2*i+1);
  endfunction

  initial begin
    Reset = 1'b1; stop = 1'b0;
    lane0 = 5'b10101; lane1 = '0; lane2 = '0; lane3 = '0;
    point0 = '0; point1 = '0; point2 = '0; point3 = '0;
    total = '0;

    // Reset frame
    tick();
    check("reset_red", red_a, 64'h0);
    check("reset_green", green_a, 64'h0);
    Reset = 1'b0;

    // Lane 0 pattern appears in column 0, row 7 empty
    tick();
    check("lane0_green", green_a, px(0,0) | px(2,0) | px(4,0));
    check("lane0_red", red_a, 64'h0);

    // Lanes 2 and 3 patterns
    lane0 = '0; lane2 = 5'b11111; lane3 = 5'b01010;
    tick();
    check("lane23_green", green_a,
          px(0,4) | px(1,4) | px(2,4) | px(3,4) | px(4,4) | px(1,6) | px(3,6));
    lane2 = '0; lane3 = '0;

    // One-cycle hit on lane 2: green for exactly 4 cycles
    point2 = 2'b01;
    tick();
    check("hit2_first", green_a, zone(2));
    point2 = 2'b00;
    for (int j = 1; j < 4; j++) begin
      tick();
      check("hit2_hold", green_a, zone(2));
      check("hit2_nored", red_a, 64'h0);
    end
    tick();
    check("hit2_off", green_a, 64'h0);

    // Miss then hit on lane 1 two cycles later
    point1 = 2'b10;
    tick();
    check("miss1_a", red_a, zone(1));
    point1 = 2'b00;
    tick();
    check("miss1_b", red_a, zone(1));
    point1 = 2'b01;
    tick();
    check("rehit1_green", green_a, zone(1));
    check("rehit1_nored", red_a, 64'h0);
    point1 = 2'b00;
    for (int j = 1; j < 4; j++) begin
      tick();
      check("rehit1_hold", green_a, zone(1));
      check("rehit1_hold_red", red_a, 64'h0);
    end
    tick();
    check("rehit1_off", green_a | red_a, 64'h0);

    // Simultaneous hits on lanes 0 and 3; point 11 on lane 1 is no event
    point0 = 2'b01; point3 = 2'b01; point1 = 2'b11;
    tick();
    check("dual_hit", green_a, zone(0) | zone(3));
    check("dual_hit_red", red_a, 64'h0);
    point0 = '0; point3 = '0; point1 = '0;
    for (int j = 0; j < 4; j++) tick();
    check("dual_off", green_a, 64'h0);

    // Score bar
    total = 5'd8;
    tick();
    check("bar8", green_a, 64'h03 << 56);
    total = 5'd13;
    tick();
    check("bar13", green_b, 64'h07 << 56);
    check("bar13_red", red_b, 64'h0);
    total = 5'd30;
    tick();
    check("bar30", green_b, 64'h7F << 56);
    total = 5'd0;
    tick();
    check("bar0_play", green_a, 64'h0);

    // Win entry and blink: 3 on, 3 off, on again; points ignored in win
    total = 5'd9;
    tick();
    check("pre_win", green_a, 64'h03 << 56);
    total = 5'd10;
    for (int j = 0; j < 7; j++) begin
      tick();
      check("win_green", green_a, (((j / 3) % 2) == 0) ? ALL_ON : 64'h0);
      check("win_red", red_a, 64'h0);
      point0 = 2'b01;
    end
    point0 = 2'b00;
    total = 5'd0;
    tick();
    check("win_exit_green", green_a, 64'h0);
    check("win_exit_red", red_a, 64'h0);

    // Stop held 20 cycles mid miss-flash on lane 3
    point3 = 2'b10;
    tick();
    check("stop_pre_a", red_a, zone(3));
    point3 = 2'b00;
    tick();
    check("stop_pre_b", red_a, zone(3));
    stop = 1'b1; lane1 = 5'b11111; total = 5'd20;
    for (int j = 0; j < 20; j++) begin
      tick();
      check("stop_red", red_a, zone(3));
      check("stop_green", green_a, 64'h0);
    end
    stop = 1'b0; lane1 = '0; total = '0;
    tick();
    check("resume_a", red_a, zone(3));
    tick();
    check("resume_b", red_a, zone(3));
    tick();
    check("resume_off", red_a, 64'h0);

    // Reset while stop is high, mid-flash
    point0 = 2'b01;
    tick();
    check("rst_pre", green_a, zone(0));
    point0 = 2'b00; stop = 1'b1; Reset = 1'b1;
    tick();
    check("rst_stop_green", green_a, 64'h0);
    check("rst_stop_red", red_a, 64'h0);
    Reset = 1'b0; stop = 1'b0;
    tick();
    check("rst_flash_gone", green_a, 64'h0);

    // Reset mid-win
    total = 5'd10;
    tick();
    check("win2_on", green_a, ALL_ON);
    Reset = 1'b1;
    tick();
    check("rst_win", green_a, 64'h0);
    Reset = 1'b0; total = 5'd0;
    tick();
    check("post_rst_play", green_a, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
